microondas_control: RTL and testbench
=====================================

# microondas_control

Top-level control FSM for the microwave; sits directly upstream of `timer`.
- Takes keypad digits and front-panel buttons and forwards each digit to the timer's serial load port.
- Drives the timer's count enable and active-low clear.
- Consumes the timer's `zero` flag to end cooking.
- Owns the magnetron enable and the end-of-cycle buzzer.

## Interface
Parameters:
- `MAX_DIGITS`, default 3: maximum keypad digits accepted per entry (M, S-tens, S-units).
- `DONE_CYCLES`, default 30: clock cycles the buzzer stays on in DONE.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe: `key_digit` is valid.
- `key_digit`  in  4  BCD keypad digit; values 10–15 are ignored.
- `start`  in  1  start/resume button, level, sampled each cycle.
- `stop_clear`  in  1  stop/clear button, level, sampled each cycle.
- `door_closed`  in  1  1 = door closed.
- `timer_zero`  in  1  `zero` output of `timer`.
- `timer_digit`  out  4  drives `timer` `in`.
- `timer_cin`  out  1  drives `timer` `Cin`: 0 = shift `timer_digit` in this cycle, 1 = count mode.
- `timer_cn`  out  1  drives `timer` `Cn`, active-low clear.
- `timer_z`  out  1  drives `timer` `z`, count enable.
- `magnetron_on`  out  1  magnetron enable.
- `buzzer`  out  1  buzzer enable.
- `state`  out  3  current FSM state, for debug and display.

## Operation
- All outputs are registered.
- Reset values:
  - state = IDLE
  - `timer_digit`=0, `timer_cin`=1, `timer_cn`=0 (timer cleared in the cycle after reset)
  - `timer_z`=0, `magnetron_on`=0, `buzzer`=0
  - digit count = 0, buzzer counter = 0
- `timer_cn` is a one-cycle low pulse. It returns to 1 on the next cycle unless a new clear is issued.
- Digit load rule: any accepted digit produces exactly one cycle with `timer_cin`=0 and `timer_digit`=digit. All other cycles hold `timer_cin`=1.
- States (encoding in package): IDLE=0, ENTRY=1, COOKING=2, PAUSED=3, DONE=4.
- IDLE
  - Valid digit (≤9) → load it, count=1, go to ENTRY.
  - `start` is ignored.
  - `stop_clear` → clear pulse, remain in IDLE.
- ENTRY
  - `stop_clear` has priority → clear pulse, count=0, go to IDLE.
  - Else `start` & `door_closed` & !`timer_zero` → COOKING.
  - Else valid digit & count<`MAX_DIGITS` → load it, count+1.
  - Digits beyond `MAX_DIGITS` are dropped; the count saturates.
  - `start` with the door open is ignored, and the state holds.
- COOKING
  - Outputs: `timer_z`=1, `magnetron_on`=1. Keypad is ignored.
  - `timer_zero` has the highest priority → DONE.
  - Else `stop_clear` or !`door_closed` → PAUSED.
- PAUSED
  - Outputs: `timer_z`=0, `magnetron_on`=0. Timer value is retained.
  - `stop_clear` → clear pulse, go to IDLE.
  - Else `start` & `door_closed` → COOKING.
- DONE
  - Outputs: `buzzer`=1, `timer_z`=0, `magnetron_on`=0.
  - The counter runs from 0 to `DONE_CYCLES`-1, then → IDLE with a clear pulse.
  - `stop_clear` ends DONE early, with the same exit action.
- `reset` overrides everything, in any state, mid-cook included: all outputs return to their reset values on the next edge.

## Timing
- Input-to-output latency is 1 cycle.
  - `key_valid` sampled at edge n → `timer_cin`=0 and the digit are valid during cycle n+1 → the timer shifts at edge n+2.
  - Back-to-back `key_valid` strobes produce back-to-back load cycles.
- `start` sampled at edge n → `timer_z`=`magnetron_on`=1 from edge n+1.
- `timer_zero` sampled at edge n → `magnetron_on` drops and `buzzer` rises at edge n+1.
- Door opening at edge n → `magnetron_on`=0 at edge n+1. This is the maximum allowed exposure.
- `buzzer` is high for exactly `DONE_CYCLES` cycles, then `timer_cn`=0 for 1 cycle.

## Structure
- `microondas_pkg` holds:
  - state encoding localparams (3-bit)
  - `MAX_DIGITS` default
  - the BCD valid-digit check function
- The package is shared with `timer` and the display decoder.
- One sub-module, `buzzer_timer`: a down-counter loaded with `DONE_CYCLES` and an expiry flag. It is reusable for other timed beeps.
- Digit count and FSM stay in the top module.

## Test plan
- **Digit entry:** keys 1, 9, 9 on consecutive cycles, then a 4th key 5 → exactly three `timer_cin`=0 cycles carrying 1, 9, 9; key 5 dropped; `timer` shows 1:99.
- **Invalid key:** key 12 in IDLE → no load cycle, state stays IDLE.
- **Cook to completion:** digits 0, 0, 3, `start` with door closed → COOKING next cycle, `magnetron_on`=1; `timer_zero` → DONE, `buzzer` high 30 cycles, then one `timer_cn`=0 pulse and IDLE.
- **Door open mid-cook:** `door_closed`=0 → PAUSED, `magnetron_on`=0 within 1 cycle, timer holds; `start` with door still open is ignored; close door + `start` resumes the count.
- **Simultaneous events:** `timer_zero` and `stop_clear` in the same COOKING cycle → DONE (not PAUSED); `stop_clear` in DONE → IDLE immediately with a clear pulse.
- **Reset mid-cook:** `reset` high one cycle during COOKING → next cycle state=IDLE, `magnetron_on`=0, `timer_z`=0, `timer_cn`=0, `timer_cin`=1.

Source files
------------

// File: rtl/microondas_pkg.sv
// Shared definitions for the microwave controller, the timer and the display decoder.
// State encoding, keypad defaults and the BCD digit check live here.
package microondas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_COOKING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int DEFAULT_MAX_DIGITS = 3;

    function automatic logic is_bcd_digit(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/buzzer_timer.sv
// Down-counter for timed beeps: load with CYCLES, count while enabled,
// expire is high during the last counted cycle.
module buzzer_timer #(
    parameter int CYCLES = 30
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(CYCLES);
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/microondas_control.sv
// Microwave control FSM: forwards keypad digits to the timer's serial load port,
// runs the timer and magnetron while cooking and sounds the buzzer at the end.
module microondas_control
    import microondas_pkg::*;
#(
    parameter int MAX_DIGITS  = DEFAULT_MAX_DIGITS,
    parameter int DONE_CYCLES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] timer_digit,
    output logic       timer_cin,
    output logic       timer_cn,
    output logic       timer_z,
    output logic       magnetron_on,
    output logic       buzzer,
    output logic [2:0] state
);

    localparam int              CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

    state_t           state_q;
    logic [CNT_W-1:0] digit_cnt;
    logic             key_ok;
    logic             buzz_load;
    logic             buzz_en;
    logic             buzz_expire;

    assign key_ok    = key_valid && is_bcd_digit(key_digit);
    assign buzz_load = (state_q == ST_COOKING) && timer_zero;
    assign buzz_en   = (state_q == ST_DONE);
    assign state     = state_q;

    buzzer_timer #(
        .CYCLES (DONE_CYCLES)
    ) u_buzzer_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (buzz_load),
        .en     (buzz_en),
        .expire (buzz_expire)
    );

    // timer_cin and timer_cn default back to inactive every cycle, so loads and
    // clears are single-cycle pulses issued only by the branches below.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            digit_cnt    <= '0;
            timer_digit  <= 4'd0;
            timer_cin    <= 1'b1;
            timer_cn     <= 1'b0;
            timer_z      <= 1'b0;
            magnetron_on <= 1'b0;
            buzzer       <= 1'b0;
        end else begin
            timer_cin <= 1'b1;
            timer_cn  <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (stop_clear) begin
                        timer_cn  <= 1'b0;
                        digit_cnt <= '0;
                    end else if (key_ok) begin
                        timer_cin   <= 1'b0;
                        timer_digit <= key_digit;
                        digit_cnt   <= CNT_W'(1);
                        state_q     <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (stop_clear) begin
                        timer_cn  <= 1'b0;
                        digit_cnt <= '0;
                        state_q   <= ST_IDLE;
                    end else if (start && door_closed && !timer_zero) begin
                        timer_z      <= 1'b1;
                        magnetron_on <= 1'b1;
                        state_q      <= ST_COOKING;
                    end else if (key_ok && digit_cnt < MAX_CNT) begin
                        timer_cin   <= 1'b0;
                        timer_digit <= key_digit;
                        digit_cnt   <= digit_cnt + 1'b1;
                    end
                end
                ST_COOKING: begin
                    // Expiry outranks a pause so a finished cook always buzzes.
                    if (timer_zero) begin
                        timer_z      <= 1'b0;
                        magnetron_on <= 1'b0;
                        buzzer       <= 1'b1;
                        state_q      <= ST_DONE;
                    end else if (stop_clear || !door_closed) begin
                        timer_z      <= 1'b0;
                        magnetron_on <= 1'b0;
                        state_q      <= ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (stop_clear) begin
                        timer_cn  <= 1'b0;
                        digit_cnt <= '0;
                        state_q   <= ST_IDLE;
                    end else if (start && door_closed) begin
                        timer_z      <= 1'b1;
                        magnetron_on <= 1'b1;
                        state_q      <= ST_COOKING;
                    end
                end
                ST_DONE: begin
                    if (stop_clear || buzz_expire) begin
                        buzzer    <= 1'b0;
                        timer_cn  <= 1'b0;
                        digit_cnt <= '0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    timer_z      <= 1'b0;
                    magnetron_on <= 1'b0;
                    buzzer       <= 1'b0;
                    digit_cnt    <= '0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microondas_control.sv
// Self-checking bench for microondas_control: load cycles are scored against a
// queue of expected digits, control outputs are checked at fixed points.
module tb_microondas_control;

    logic       clock;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop_clear;
    logic       door_closed;
    logic       timer_zero;
    logic [3:0] timer_digit;
    logic       timer_cin;
    logic       timer_cn;
    logic       timer_z;
    logic       magnetron_on;
    logic       buzzer;
    logic [2:0] state;

    logic [3:0] exp_q[$];
    int         n_checks;
    int         n_errors;
    int         m_cnt;
    int         n_loads;

    microondas_control #(
        .MAX_DIGITS  (3),
        .DONE_CYCLES (30)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .start        (start),
        .stop_clear   (stop_clear),
        .door_closed  (door_closed),
        .timer_zero   (timer_zero),
        .timer_digit  (timer_digit),
        .timer_cin    (timer_cin),
        .timer_cn     (timer_cn),
        .timer_z      (timer_z),
        .magnetron_on (magnetron_on),
        .buzzer       (buzzer),
        .state        (state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one key strobe for one cycle; the entry model decides whether it loads.
    task automatic press_key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        if (d <= 4'd9 && m_cnt < 3) begin
            exp_q.push_back(d);
            m_cnt++;
        end
        tick();
    endtask

    task automatic release_keys();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_clear = 1'b1;
        tick();
        stop_clear = 1'b0;
    endtask

    // scoreboard: every load cycle must match the head of the expected queue
    always @(negedge clock) begin
        if (!reset && timer_cin == 1'b0) begin
            n_loads++;
            if (exp_q.size() == 0) begin
                check("load_unexpected", {4'd0, timer_digit}, 8'hFF);
            end else begin
                check("load_digit", {4'd0, timer_digit}, {4'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int n_buzz;
        logic [3:0] d;
        n_checks    = 0;
        n_errors    = 0;
        n_loads     = 0;
        m_cnt       = 0;
        reset       = 1'b1;
        key_valid   = 1'b0;
        key_digit   = 4'd0;
        start       = 1'b0;
        stop_clear  = 1'b0;
        door_closed = 1'b1;
        timer_zero  = 1'b0;

        tick();
        tick();
        @(negedge clock);
        check("rst_state", {5'd0, state}, 8'd0);
        check("rst_digit", {4'd0, timer_digit}, 8'd0);
        check("rst_cin", {7'd0, timer_cin}, 8'd1);
        check("rst_cn", {7'd0, timer_cn}, 8'd0);
        check("rst_z", {7'd0, timer_z}, 8'd0);
        check("rst_mag", {7'd0, magnetron_on}, 8'd0);
        check("rst_buzzer", {7'd0, buzzer}, 8'd0);
        tick();
        reset = 1'b0;
        tick();
        @(negedge clock);
        check("cn_release", {7'd0, timer_cn}, 8'd1);

        // digit entry 1,9,9 then a dropped 5
        m_cnt = 0;
        press_key(4'd1);
        press_key(4'd9);
        press_key(4'd9);
        press_key(4'd5);
        release_keys();
        tick();
        tick();
        @(negedge clock);
        check("entry_state", {5'd0, state}, 8'd1);
        check("entry_loads", 8'(n_loads), 8'd3);
        check("entry_q_empty", 8'(exp_q.size()), 8'd0);
        pulse_stop();
        @(negedge clock);
        check("entry_clear_cn", {7'd0, timer_cn}, 8'd0);
        check("entry_clear_state", {5'd0, state}, 8'd0);

        // invalid key in IDLE
        press_key(4'd12);
        release_keys();
        @(negedge clock);
        check("bad_key_state", {5'd0, state}, 8'd0);
        check("bad_key_cin", {7'd0, timer_cin}, 8'd1);

        // random key bursts, including invalid codes and overflow
        for (int r = 0; r < 4; r++) begin
            m_cnt = 0;
            for (int k = 0; k < 5; k++) begin
                d = 4'($urandom_range(0, 15));
                press_key(d);
            end
            release_keys();
            tick();
            @(negedge clock);
            check("rand_state", {5'd0, state}, (m_cnt > 0) ? 8'd1 : 8'd0);
            pulse_stop();
            tick();
        end

        // cook to completion
        m_cnt = 0;
        press_key(4'd0);
        press_key(4'd0);
        press_key(4'd3);
        release_keys();
        pulse_start();
        @(negedge clock);
        check("cook_state", {5'd0, state}, 8'd2);
        check("cook_mag", {7'd0, magnetron_on}, 8'd1);
        check("cook_z", {7'd0, timer_z}, 8'd1);
        tick();
        tick();
        tick();
        timer_zero = 1'b1;
        tick();
        timer_zero = 1'b0;
        @(negedge clock);
        check("done_state", {5'd0, state}, 8'd4);
        check("done_buzzer", {7'd0, buzzer}, 8'd1);
        check("done_mag", {7'd0, magnetron_on}, 8'd0);
        n_buzz = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (buzzer) n_buzz++;
            else break;
        end
        check("buzz_cycles", 8'(n_buzz), 8'd30);
        check("done_exit_cn", {7'd0, timer_cn}, 8'd0);
        check("done_exit_state", {5'd0, state}, 8'd0);
        @(negedge clock);
        check("done_cn_release", {7'd0, timer_cn}, 8'd1);

        // door open mid-cook
        m_cnt = 0;
        press_key(4'd1);
        release_keys();
        pulse_start();
        tick();
        door_closed = 1'b0;
        tick();
        @(negedge clock);
        check("door_state", {5'd0, state}, 8'd3);
        check("door_mag", {7'd0, magnetron_on}, 8'd0);
        check("door_z", {7'd0, timer_z}, 8'd0);
        pulse_start();
        @(negedge clock);
        check("door_open_start", {5'd0, state}, 8'd3);
        door_closed = 1'b1;
        pulse_start();
        @(negedge clock);
        check("resume_state", {5'd0, state}, 8'd2);
        check("resume_mag", {7'd0, magnetron_on}, 8'd1);

        // timer_zero and stop_clear together, then stop in DONE
        timer_zero = 1'b1;
        stop_clear = 1'b1;
        tick();
        timer_zero = 1'b0;
        stop_clear = 1'b0;
        @(negedge clock);
        check("simul_state", {5'd0, state}, 8'd4);
        tick();
        pulse_stop();
        @(negedge clock);
        check("stop_done_state", {5'd0, state}, 8'd0);
        check("stop_done_cn", {7'd0, timer_cn}, 8'd0);
        check("stop_done_buzzer", {7'd0, buzzer}, 8'd0);

        // start with door open in ENTRY, then reset mid-cook
        m_cnt = 0;
        press_key(4'd2);
        release_keys();
        door_closed = 1'b0;
        pulse_start();
        @(negedge clock);
        check("entry_door_open", {5'd0, state}, 8'd1);
        door_closed = 1'b1;
        pulse_start();
        tick();
        @(negedge clock);
        check("pre_reset_state", {5'd0, state}, 8'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_state", {5'd0, state}, 8'd0);
        check("mid_rst_mag", {7'd0, magnetron_on}, 8'd0);
        check("mid_rst_z", {7'd0, timer_z}, 8'd0);
        check("mid_rst_cn", {7'd0, timer_cn}, 8'd0);
        check("mid_rst_cin", {7'd0, timer_cin}, 8'd1);

        tick();
        tick();
        @(negedge clock);
        check("final_q_empty", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
